// File: rtl/turn_signal_scheduler.sv
// Tail-light front-end: debounces driver switches, arbitrates turn/hazard requests into one
// mode, paces the flash sequence with a one-cycle step enable and drives the dim PWM.
module turn_signal_scheduler #(
    parameter int DEB_CYCLES = 16,
    parameter int STEP_DIV   = 4096,
    parameter int DIM_PERIOD = 64,
    parameter int DIM_DUTY   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left_in,
    input  logic       right_in,
    input  logic       brk_in,
    input  logic       hzd_in,
    input  logic       rlight,
    output logic       left,
    output logic       right,
    output logic       brk,
    output logic       hzd,
    output logic       step,
    output logic [1:0] phase,
    output logic       dim
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int SW = $clog2(STEP_DIV);
    localparam int PW = $clog2(DIM_PERIOD);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
    localparam logic [PW-1:0] DIM_LAST  = PW'(DIM_PERIOD - 1);
    localparam logic [PW:0]   DUTY      = (PW + 1)'(DIM_DUTY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN_L = 2'd1,
        TURN_R = 2'd2,
        HAZ    = 2'd3
    } mode_t;

    // Bit order: 0 left, 1 right, 2 brake, 3 hazard.
    logic [3:0]    raw;
    logic [3:0]    deb;
    logic [DW-1:0] deb_cnt [4];

    assign raw = {hzd_in, brk_in, right_in, left_in};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (raw[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= ~deb[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic h_req, l_req, r_req;

    assign h_req = deb[3] | (deb[0] & deb[1]);
    assign l_req = deb[0] & ~deb[1] & ~deb[3];
    assign r_req = deb[1] & ~deb[0] & ~deb[3];

    mode_t         mode, mode_next, req_mode;
    logic [SW-1:0] pre_cnt;
    logic          boundary;

    assign step     = (mode != IDLE) && (pre_cnt == STEP_LAST);
    assign boundary = step && (phase == 2'd3);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        req_mode  = IDLE;
        mode_next = mode;
        if (h_req)      req_mode = HAZ;
        else if (l_req) req_mode = TURN_L;
        else if (r_req) req_mode = TURN_R;

        // Hazard preempts at once; any other change waits for the end of the running sequence.
        if (mode == IDLE || boundary) mode_next = req_mode;
        else if (h_req)               mode_next = HAZ;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mode <= IDLE;
        else      mode <= mode_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
            phase   <= 2'd0;
        end else if (mode_next != mode) begin
            pre_cnt <= '0;
            phase   <= 2'd0;
        end else if (mode != IDLE) begin
            if (step) begin
                pre_cnt <= '0;
                phase   <= phase + 2'd1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    assign left  = (mode == TURN_L);
    assign right = (mode == TURN_R);
    assign hzd   = (mode == HAZ);
    assign brk   = deb[2];

    logic [PW-1:0] dim_cnt;

    // dim is registered so that it too reads 0 while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dim_cnt <= '0;
            dim     <= 1'b0;
        end else begin
            dim_cnt <= (dim_cnt == DIM_LAST) ? '0 : dim_cnt + 1'b1;
            dim     <= rlight && ({1'b0, dim_cnt} < DUTY);
        end
    end

endmodule
